vx_tlb: RTL and testbench
=========================

Name: vx_tlb

Overview:
- Small fully-associative translation lookaside buffer, directly upstream of the page table walker.
- Accepts virtual page number (VPN) lookups from the cache/LSU side.
- Hit: returns physical page number (PPN).
- Miss: raises a one-cycle miss request to the walker, waits for its completion, refills an entry and returns the walked translation or a fault.

Parameters:
- NUM_ENTRIES, 8, number of TLB entries; power of two, minimum 2.
- VPN_WIDTH, 27, virtual page number width (Sv39).
- PPN_WIDTH, 44, physical page number width (Sv39).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  lookup request valid
- req_vpn  in  VPN_WIDTH  VPN to translate
- req_ready  out  1  block can accept a lookup
- rsp_valid  out  1  translation result valid
- rsp_ppn  out  PPN_WIDTH  translated PPN
- rsp_fault  out  1  translation failed; rsp_ppn is 0
- rsp_ready  in  1  consumer accepts the result
- tlb_miss  out  1  one-cycle miss request to walker
- miss_vpn  out  VPN_WIDTH  VPN being walked
- ptw_busy  in  1  walker busy
- ptw_done  in  1  one-cycle walk-complete pulse
- ptw_ppn  in  PPN_WIDTH  walked PPN, valid with ptw_done
- ptw_error  in  2  0 no error, 1 invalid, 2 no leaf, 3 permission
- flush  in  1  invalidate all entries (sfence.vma)

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - state IDLE, all entry valid bits 0, victim pointer 0.
  - rsp_valid=0, rsp_ppn=0, rsp_fault=0, tlb_miss=0, miss_vpn=0.
  - req_ready=1.
- Reset mid-walk: return to IDLE; any later ptw_done is ignored while in IDLE.
- States: IDLE, LOOKUP, MISS, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_vpn, go to LOOKUP.
- LOOKUP:
  - req_ready=0.
  - Compare the latched VPN against all valid entries in parallel.
  - Hit: load rsp_ppn from the matching entry, rsp_fault=0, go to RESP. rsp_valid is high at T+2, where T is the accept cycle.
  - Miss: go to MISS.
  - Multiple matching entries must not occur; if they do, the lowest index wins.
- MISS:
  - If ptw_busy=0: assert tlb_miss for exactly one cycle with miss_vpn = latched VPN, go to WAIT.
  - If ptw_busy=1: hold in MISS with tlb_miss=0.
- WAIT:
  - Stay until ptw_done.
  - ptw_done with ptw_error=0: write {valid, VPN, ptw_ppn} into the victim entry, rsp_ppn=ptw_ppn, rsp_fault=0.
  - ptw_done with ptw_error!=0: no fill, rsp_ppn=0, rsp_fault=1.
  - In both cases go to RESP.
- RESP:
  - rsp_valid=1; outputs held stable until rsp_ready.
  - On rsp_ready: go to IDLE, rsp_valid=0 next cycle.
  - No back-to-back accept: the next request is accepted in IDLE, so a request needs a minimum of 3 cycles.
- Victim selection:
  - Use the lowest-index invalid entry.
  - If none is invalid, use the round-robin pointer, which increments (wraps at NUM_ENTRIES-1 to 0) only on a fill that used it.
- Flush:
  - Clears all valid bits in one cycle, in any state.
  - Flush on the same cycle as a fill: flush wins, entry not written, response still delivered.
  - Flush during LOOKUP: lookup treated as a miss.
  - Flush does not cancel an outstanding walk or pending response.
- ptw_done outside WAIT is ignored.

Optional Feature:
- Macro VX_TLB_PERF_EN.
- When defined:
  - Adds outputs perf_hits and perf_misses, 32 bits each, reset to 0.
  - perf_hits increments on each LOOKUP hit; perf_misses on each LOOKUP miss.
  - Counters wrap at 2^32; they are not cleared by flush.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then req_vpn=0x1234 -> tlb_miss pulse 1 cycle with miss_vpn=0x1234. Then ptw_done, ptw_ppn=0xABCD, error=0 -> rsp_valid, rsp_ppn=0xABCD, rsp_fault=0.
- Repeat req_vpn=0x1234 -> hit, rsp_valid at T+2, rsp_ppn=0xABCD, no tlb_miss.
- Miss on VPN 0x55 with ptw_error=3 -> rsp_fault=1, rsp_ppn=0; a re-request of 0x55 misses again.
- Fill 9 distinct VPNs (NUM_ENTRIES=8) -> 9th replaces entry 0; first VPN misses, VPNs 2-9 hit.
- Flush while in WAIT coincident with ptw_done -> response delivered, subsequent lookup of that VPN misses; miss with ptw_busy=1 for 5 cycles -> tlb_miss delayed until ptw_busy=0.
- Hold rsp_ready=0 for 4 cycles -> rsp_valid/rsp_ppn stable, req_ready=0; with VX_TLB_PERF_EN, after scenarios 1-2 perf_hits=1, perf_misses=1.

Source files
------------

// File: rtl/vx_tlb_if.sv
// rtl/vx_tlb_if.sv - lookup, response, walker and flush signals of vx_tlb
//
// Groups every non-clock/reset signal of the TLB.
//   slave  : the TLB side (drives req_ready, rsp_*, tlb_miss, miss_vpn)
//   master : the LSU/walker side (drives req_*, rsp_ready, ptw_*, flush)
interface vx_tlb_if #(
    parameter int VPN_WIDTH = 27,
    parameter int PPN_WIDTH = 44
);
    logic                 req_valid;
    logic [VPN_WIDTH-1:0] req_vpn;
    logic                 req_ready;
    logic                 rsp_valid;
    logic [PPN_WIDTH-1:0] rsp_ppn;
    logic                 rsp_fault;
    logic                 rsp_ready;
    logic                 tlb_miss;
    logic [VPN_WIDTH-1:0] miss_vpn;
    logic                 ptw_busy;
    logic                 ptw_done;
    logic [PPN_WIDTH-1:0] ptw_ppn;
    logic [1:0]           ptw_error;
    logic                 flush;

    modport slave (
        input  req_valid, req_vpn, rsp_ready, ptw_busy, ptw_done, ptw_ppn, ptw_error, flush,
        output req_ready, rsp_valid, rsp_ppn, rsp_fault, tlb_miss, miss_vpn
    );

    modport master (
        output req_valid, req_vpn, rsp_ready, ptw_busy, ptw_done, ptw_ppn, ptw_error, flush,
        input  req_ready, rsp_valid, rsp_ppn, rsp_fault, tlb_miss, miss_vpn
    );
endinterface

// File: rtl/vx_tlb.sv
// rtl/vx_tlb.sv - fully-associative TLB in front of the page table walker
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : lookup request/response, walker miss/done handshake, flush
//   perf_hits    : (VX_TLB_PERF_EN only) count of LOOKUP hits, wraps at 2^32
//   perf_misses  : (VX_TLB_PERF_EN only) count of LOOKUP misses, wraps at 2^32
// Optional feature macro: VX_TLB_PERF_EN
module vx_tlb #(
    parameter int NUM_ENTRIES = 8,
    parameter int VPN_WIDTH   = 27,
    parameter int PPN_WIDTH   = 44
) (
    input  logic         clk,
    input  logic         reset,
    vx_tlb_if.slave      bus
`ifdef VX_TLB_PERF_EN
    ,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses
`endif
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, WAIT, RESP} state_t;

    state_t               state;
    logic [VPN_WIDTH-1:0] vpn_q;
    logic [NUM_ENTRIES-1:0] valid;
    logic [VPN_WIDTH-1:0] tag_arr [NUM_ENTRIES];
    logic [PPN_WIDTH-1:0] ppn_arr [NUM_ENTRIES];
    logic [IDX_W-1:0]     rr_ptr;

    logic                 req_ready_q;
    logic                 rsp_valid_q;
    logic [PPN_WIDTH-1:0] rsp_ppn_q;
    logic                 rsp_fault_q;
    logic                 tlb_miss_q;
    logic [VPN_WIDTH-1:0] miss_vpn_q;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_ppn   = rsp_ppn_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.tlb_miss  = tlb_miss_q;
    assign bus.miss_vpn  = miss_vpn_q;

    // Parallel tag match; scanning downward leaves the lowest matching index.
    logic             any_match;
    logic [IDX_W-1:0] hit_idx;
    logic             hit;

    always_comb begin
        any_match = 1'b0;
        hit_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (tag_arr[i] == vpn_q)) begin
                any_match = 1'b1;
                hit_idx   = IDX_W'(i);
            end
        end
    end

    // A flush landing on the compare cycle must not return a stale entry.
    assign hit = any_match && !bus.flush;

    // Victim: lowest invalid entry, otherwise the round-robin pointer.
    logic [IDX_W-1:0] victim_idx;
    logic             victim_is_rr;

    always_comb begin
        victim_idx   = rr_ptr;
        victim_is_rr = 1'b1;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                victim_idx   = IDX_W'(i);
                victim_is_rr = 1'b0;
            end
        end
    end

    // A flush in the same cycle as a fill suppresses the write.
    logic fill_en;
    assign fill_en = (state == WAIT) && bus.ptw_done && (bus.ptw_error == 2'd0) && !bus.flush;

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_arr[victim_idx] <= vpn_q;
            ppn_arr[victim_idx] <= bus.ptw_ppn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            vpn_q       <= '0;
            valid       <= '0;
            rr_ptr      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_ppn_q   <= '0;
            rsp_fault_q <= 1'b0;
            tlb_miss_q  <= 1'b0;
            miss_vpn_q  <= '0;
`ifdef VX_TLB_PERF_EN
            perf_hits   <= '0;
            perf_misses <= '0;
`endif
        end else begin
            tlb_miss_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        vpn_q       <= bus.req_vpn;
                        req_ready_q <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        rsp_ppn_q   <= ppn_arr[hit_idx];
                        rsp_fault_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
`ifdef VX_TLB_PERF_EN
                        perf_hits   <= perf_hits + 32'd1;
`endif
                    end else begin
                        state       <= MISS;
`ifdef VX_TLB_PERF_EN
                        perf_misses <= perf_misses + 32'd1;
`endif
                    end
                end
                MISS: begin
                    if (!bus.ptw_busy) begin
                        tlb_miss_q <= 1'b1;
                        miss_vpn_q <= vpn_q;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.ptw_done) begin
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                        if (bus.ptw_error == 2'd0) begin
                            rsp_ppn_q   <= bus.ptw_ppn;
                            rsp_fault_q <= 1'b0;
                            if (fill_en) begin
                                valid[victim_idx] <= 1'b1;
                                if (victim_is_rr) begin
                                    rr_ptr <= rr_ptr + IDX_W'(1);
                                end
                            end
                        end else begin
                            rsp_ppn_q   <= '0;
                            rsp_fault_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (bus.flush) begin
                valid <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vx_tlb.sv
// tb/tb_vx_tlb.sv - directed self-checking bench for vx_tlb
module tb_vx_tlb;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_tlb_if bus ();

`ifdef VX_TLB_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    vx_tlb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef VX_TLB_PERF_EN
        ,
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [26:0] vpn);
        bus.req_valid = 1'b1;
        bus.req_vpn   = vpn;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic accept_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // Full lookup; services a walk if one is requested. lat = cycles from accept to rsp_valid.
    task automatic transact(input logic [26:0] vpn, input logic [43:0] ppn, input logic [1:0] err,
                            input logic flush_lookup, output logic saw_miss, output logic [26:0] mvpn,
                            output int pulses, output int lat, output logic [43:0] ppn_o,
                            output logic fault_o, output logic timed_out);
        saw_miss = 1'b0; mvpn = '0; pulses = 0; lat = 0; ppn_o = '0; fault_o = 1'b0; timed_out = 1'b1;
        issue(vpn);
        bus.flush = flush_lookup;
        for (int i = 1; i < 40; i++) begin
            tick();
            bus.flush = 1'b0;
            if (bus.tlb_miss) begin
                saw_miss = 1'b1;
                pulses++;
                mvpn = bus.miss_vpn;
                tick();
                if (bus.tlb_miss) pulses++;
                bus.ptw_done  = 1'b1;
                bus.ptw_ppn   = ppn;
                bus.ptw_error = err;
                tick();
                bus.ptw_done  = 1'b0;
                bus.ptw_error = 2'd0;
            end
            if (bus.rsp_valid) begin
                lat = i + 1;
                ppn_o = bus.rsp_ppn;
                fault_o = bus.rsp_fault;
                timed_out = 1'b0;
                break;
            end
        end
        accept_rsp();
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
        vectors++; if (bus.rsp_ppn !== 44'h0) begin miscompares++; $display("FAIL reset_rsp_ppn got %h want 0", bus.rsp_ppn); end
        vectors++; if (bus.rsp_fault !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_fault got %0b want 0", bus.rsp_fault); end
        vectors++; if (bus.tlb_miss !== 1'b0) begin miscompares++; $display("FAIL reset_tlb_miss got %0b want 0", bus.tlb_miss); end
        vectors++; if (bus.miss_vpn !== 27'h0) begin miscompares++; $display("FAIL reset_miss_vpn got %h want 0", bus.miss_vpn); end
`ifdef VX_TLB_PERF_EN
        vectors++; if (perf_hits !== 32'd0 || perf_misses !== 32'd0) begin miscompares++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_hits, perf_misses); end
`endif
    endtask

    task automatic test_miss_fill();
        logic sm, f, to; logic [26:0] mv; logic [43:0] p; int pu, lat;
        transact(27'h1234, 44'hABCD, 2'd0, 1'b0, sm, mv, pu, lat, p, f, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL miss_fill_timeout got %0b want 0", to); end
        vectors++; if (sm !== 1'b1) begin miscompares++; $display("FAIL miss_fill_tlb_miss got %0b want 1", sm); end
        vectors++; if (pu !== 1) begin miscompares++; $display("FAIL miss_fill_pulse_len got %0d want 1", pu); end
        vectors++; if (mv !== 27'h1234) begin miscompares++; $display("FAIL miss_fill_miss_vpn got %h want 1234", mv); end
        vectors++; if (p !== 44'hABCD) begin miscompares++; $display("FAIL miss_fill_ppn got %h want abcd", p); end
        vectors++; if (f !== 1'b0) begin miscompares++; $display("FAIL miss_fill_fault got %0b want 0", f); end
    endtask

    task automatic test_hit();
        logic sm, f, to; logic [26:0] mv; logic [43:0] p; int pu, lat;
        transact(27'h1234, 44'hDEAD, 2'd0, 1'b0, sm, mv, pu, lat, p, f, to);
        vectors++; if (sm !== 1'b0) begin miscompares++; $display("FAIL hit_no_miss got %0b want 0", sm); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL hit_latency got %0d want 2", lat); end
        vectors++; if (p !== 44'hABCD) begin miscompares++; $display("FAIL hit_ppn got %h want abcd", p); end
        vectors++; if (f !== 1'b0) begin miscompares++; $display("FAIL hit_fault got %0b want 0", f); end
`ifdef VX_TLB_PERF_EN
        vectors++; if (perf_hits !== 32'd1) begin miscompares++; $display("FAIL perf_hits got %0d want 1", perf_hits); end
        vectors++; if (perf_misses !== 32'd1) begin miscompares++; $display("FAIL perf_misses got %0d want 1", perf_misses); end
`endif
    endtask

    task automatic test_fault();
        logic sm, f, to; logic [26:0] mv; logic [43:0] p; int pu, lat;
        transact(27'h55, 44'h777, 2'd3, 1'b0, sm, mv, pu, lat, p, f, to);
        vectors++; if (sm !== 1'b1) begin miscompares++; $display("FAIL fault_miss got %0b want 1", sm); end
        vectors++; if (f !== 1'b1) begin miscompares++; $display("FAIL fault_flag got %0b want 1", f); end
        vectors++; if (p !== 44'h0) begin miscompares++; $display("FAIL fault_ppn got %h want 0", p); end
        transact(27'h55, 44'h999, 2'd0, 1'b0, sm, mv, pu, lat, p, f, to);
        vectors++; if (sm !== 1'b1) begin miscompares++; $display("FAIL fault_rerequest_miss got %0b want 1", sm); end
        vectors++; if (p !== 44'h999) begin miscompares++; $display("FAIL fault_rerequest_ppn got %h want 999", p); end
    endtask

    task automatic test_replace();
        logic sm, f, to; logic [26:0] mv; logic [43:0] p; int pu, lat;
        do_flush();
        for (int i = 0; i < 9; i++) begin
            transact(27'h100 + 27'(i), 44'h2000 + 44'(i), 2'd0, 1'b0, sm, mv, pu, lat, p, f, to);
            vectors++; if (sm !== 1'b1 || to !== 1'b0) begin miscompares++; $display("FAIL replace_fill_%0d got miss=%0b timeout=%0b want 1/0", i, sm, to); end
        end
        for (int i = 1; i < 9; i++) begin
            transact(27'h100 + 27'(i), 44'hFFFF, 2'd0, 1'b0, sm, mv, pu, lat, p, f, to);
            vectors++; if (sm !== 1'b0 || p !== 44'h2000 + 44'(i)) begin miscompares++; $display("FAIL replace_hit_%0d got miss=%0b ppn=%h want 0/%h", i, sm, p, 44'h2000 + 44'(i)); end
        end
        transact(27'h100, 44'h2100, 2'd0, 1'b0, sm, mv, pu, lat, p, f, to);
        vectors++; if (sm !== 1'b1) begin miscompares++; $display("FAIL replace_evicted_miss got %0b want 1", sm); end
    endtask

    task automatic test_flush_wait();
        logic sm, f, to, seen; logic [26:0] mv; logic [43:0] p; int pu, lat;
        seen = 1'b0;
        issue(27'h4242);
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = bus.tlb_miss;
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL flush_wait_miss got %0b want 1", seen); end
        tick();
        bus.ptw_done = 1'b1; bus.ptw_ppn = 44'h4444; bus.flush = 1'b1;
        tick();
        bus.ptw_done = 1'b0; bus.flush = 1'b0;
        vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL flush_wait_rsp_valid got %0b want 1", bus.rsp_valid); end
        vectors++; if (bus.rsp_ppn !== 44'h4444) begin miscompares++; $display("FAIL flush_wait_rsp_ppn got %h want 4444", bus.rsp_ppn); end
        accept_rsp();
        transact(27'h4242, 44'h4545, 2'd0, 1'b0, sm, mv, pu, lat, p, f, to);
        vectors++; if (sm !== 1'b1) begin miscompares++; $display("FAIL flush_wait_not_filled got %0b want 1", sm); end
    endtask

    task automatic test_busy();
        logic early;
        early = 1'b0;
        bus.ptw_busy = 1'b1;
        issue(27'h3333);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.tlb_miss) early = 1'b1;
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL busy_held_miss got %0b want 0", early); end
        bus.ptw_busy = 1'b0;
        tick();
        vectors++; if (bus.tlb_miss !== 1'b1) begin miscompares++; $display("FAIL busy_release_miss got %0b want 1", bus.tlb_miss); end
        vectors++; if (bus.miss_vpn !== 27'h3333) begin miscompares++; $display("FAIL busy_miss_vpn got %h want 3333", bus.miss_vpn); end
        tick();
        vectors++; if (bus.tlb_miss !== 1'b0) begin miscompares++; $display("FAIL busy_miss_one_cycle got %0b want 0", bus.tlb_miss); end
        bus.ptw_done = 1'b1; bus.ptw_ppn = 44'h3030;
        tick();
        bus.ptw_done = 1'b0;
        vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_ppn !== 44'h3030) begin miscompares++; $display("FAIL busy_rsp got valid=%0b ppn=%h want 1/3030", bus.rsp_valid, bus.rsp_ppn); end
        accept_rsp();
    endtask

    task automatic test_stall();
        issue(27'h3333);
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_ppn !== 44'h3030 || bus.req_ready !== 1'b0)
                begin miscompares++; $display("FAIL stall_cycle_%0d got valid=%0b ppn=%h ready=%0b want 1/3030/0", i, bus.rsp_valid, bus.rsp_ppn, bus.req_ready); end
            tick();
        end
        accept_rsp();
        vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release got valid=%0b ready=%0b want 0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_flush_lookup();
        logic sm, f, to; logic [26:0] mv; logic [43:0] p; int pu, lat;
        transact(27'h3333, 44'h3131, 2'd0, 1'b1, sm, mv, pu, lat, p, f, to);
        vectors++; if (sm !== 1'b1 || p !== 44'h3131) begin miscompares++; $display("FAIL flush_lookup got miss=%0b ppn=%h want 1/3131", sm, p); end
    endtask

    task automatic test_reset_mid_walk();
        logic sm, f, to; logic [26:0] mv; logic [43:0] p; int pu, lat;
        issue(27'h7777);
        tick();
        tick();
        vectors++; if (bus.tlb_miss !== 1'b1) begin miscompares++; $display("FAIL midwalk_miss got %0b want 1", bus.tlb_miss); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.ptw_done = 1'b1; bus.ptw_ppn = 44'h7070;
        tick();
        bus.ptw_done = 1'b0;
        tick();
        vectors++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.miss_vpn !== 27'h0)
            begin miscompares++; $display("FAIL midwalk_ignored got valid=%0b ready=%0b mvpn=%h want 0/1/0", bus.rsp_valid, bus.req_ready, bus.miss_vpn); end
        transact(27'h7777, 44'h7171, 2'd0, 1'b0, sm, mv, pu, lat, p, f, to);
        vectors++; if (sm !== 1'b1 || p !== 44'h7171) begin miscompares++; $display("FAIL midwalk_no_fill got miss=%0b ppn=%h want 1/7171", sm, p); end
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_vpn = '0; bus.rsp_ready = 1'b0;
        bus.ptw_busy = 1'b0; bus.ptw_done = 1'b0; bus.ptw_ppn = '0;
        bus.ptw_error = 2'd0; bus.flush = 1'b0;
        test_reset();
        test_miss_fill();
        test_hit();
        test_fault();
        test_replace();
        test_flush_wait();
        test_busy();
        test_stall();
        test_flush_lookup();
        test_reset_mid_walk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
